// File: rtl/particle_stream_ingest.sv
// Particle-word ingress: a framed host stream is dealt round-robin into per-lane
// FIFOs with registered heads, with frame counting and sticky drop/stray flags.
module particle_stream_ingest #(
  parameter int DATA_WIDTH   = 128,
  parameter int NUM_CHANNELS = 2,
  parameter int FIFO_DEPTH   = 16,
  parameter int NUM_WORDS    = 2048,
  parameter int CNT_W        = $clog2(NUM_WORDS + 1)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [DATA_WIDTH-1:0]              user_buffer_data,
  input  logic                               user_data_available,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] out_data,
  output logic [NUM_CHANNELS-1:0]            out_valid,
  input  logic [NUM_CHANNELS-1:0]            out_ready,
  output logic [CNT_W-1:0]                   word_count,
  output logic                               busy,
  output logic                               done,
  output logic                               overflow,
  output logic                               extra_data
);
  localparam int PTR_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
  state_t state, state_next;

  logic [PTR_W-1:0]        lane_ptr;
  logic [NUM_CHANNELS-1:0] lane_full;
  logic [NUM_CHANNELS-1:0] lane_empty;
  logic                    accept;
  logic                    arm;
  logic                    last_word;

  assign arm       = start && ((state == IDLE) || (state == DONE));
  assign accept    = (state == LOAD) && user_data_available;
  assign last_word = (word_count == CNT_W'(NUM_WORDS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    if (accept && last_word) state_next = DRAIN;
      DRAIN:   if (&lane_empty) state_next = DONE;
      DONE:    if (start) state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == LOAD) || (state == DRAIN);
    done = (state == DONE);
  end

  // Dropped words still advance the pointer so word k always maps to lane k mod N.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_ptr   <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
      extra_data <= 1'b0;
    end else if (arm) begin
      lane_ptr   <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
      extra_data <= user_data_available;
    end else begin
      if (user_data_available && (state != LOAD)) extra_data <= 1'b1;
      if (accept) begin
        lane_ptr   <= (lane_ptr == PTR_W'(NUM_CHANNELS - 1)) ? '0 : lane_ptr + PTR_W'(1);
        word_count <= word_count + CNT_W'(1);
        if (lane_full[lane_ptr]) overflow <= 1'b1;
      end
    end
  end

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_lane
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [AW:0]           mem_count;
    logic [AW:0]           occupancy;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  head_valid;
    logic                  push;
    logic                  pop;
    logic                  mem_empty;
    logic                  head_load;

    // The head register counts toward capacity, so a lane holds FIFO_DEPTH words in total.
    assign mem_count     = wr_ptr - rd_ptr;
    assign mem_empty     = (wr_ptr == rd_ptr);
    assign occupancy     = mem_count + {{AW{1'b0}}, head_valid};
    assign lane_full[c]  = (occupancy == (AW+1)'(FIFO_DEPTH));
    assign lane_empty[c] = mem_empty && !head_valid;
    assign push          = accept && (lane_ptr == PTR_W'(c)) && !lane_full[c];
    assign pop           = head_valid && out_ready[c];
    assign head_load     = !mem_empty && (!head_valid || pop);

    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= user_buffer_data;
    end

    // Stage boundary: storage array -> registered lane head.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        head_valid <= 1'b0;
        head_data  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
        if (head_load) begin
          rd_ptr     <= rd_ptr + (AW+1)'(1);
          head_data  <= mem[rd_ptr[AW-1:0]];
          head_valid <= 1'b1;
        end else if (pop) begin
          head_valid <= 1'b0;
        end
      end
    end

    assign out_data[c*DATA_WIDTH +: DATA_WIDTH] = head_data;
    assign out_valid[c]                         = head_valid;
  end

endmodule
